// File: rtl/mdu_iterative.sv
// Iterative RISC-V M-extension multiply/divide unit: shift-add multiplier and
// restoring divider sharing one datapath, valid/ready on both sides.
module mdu_iterative #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned W2 = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_mcand;
  logic            r_neg;
  logic            r_neg_rem;
  logic            r_special;
  logic [XLEN-1:0] r_result;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;

  logic            w_accept;
  logic            w_sa;
  logic            w_sb;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN:0]   w_div_trial;
  logic [W2-1:0]   w_prod;
  logic [XLEN-1:0] w_quot;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_final;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign result    = r_result;

  assign w_accept = (r_state == S_IDLE) && in_valid && !flush;

  // a is unsigned only for MULHU/DIVU/REMU; b is signed for MUL/MULH/DIV/REM
  assign w_sa    = a[XLEN-1] & ~(op[0] & (op[1] | op[2]));
  assign w_sb    = b[XLEN-1] & (op[2] ? ~op[0] : ~op[1]);
  assign w_abs_a = w_sa ? (~a + XLEN'(1)) : a;
  assign w_abs_b = w_sb ? (~b + XLEN'(1)) : b;
  assign w_div0  = op[2] && (b == '0);
  assign w_ovf   = op[2] && !op[0] && (a == MOST_NEG) && (b == '1);

  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
  assign w_div_trial = {r_hi, r_lo[XLEN-1]} - {1'b0, r_mcand};

  // Sign correction applied once, after the magnitude iterations
  assign w_prod = r_neg ? (~{r_hi, r_lo} + W2'(1)) : {r_hi, r_lo};
  assign w_quot = r_neg ? (~r_lo + XLEN'(1)) : r_lo;
  assign w_rem  = r_neg_rem ? (~r_hi + XLEN'(1)) : r_hi;

  always_comb begin
    w_final = '0;
    if (r_special)
      w_final = r_hi;
    else if (!r_op[2])
      w_final = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[W2-1:XLEN];
    else
      w_final = r_op[1] ? w_rem : w_quot;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_BUSY;
      S_BUSY:  if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush)
      w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt == S_BUSY) || (w_state_nxt == S_DONE);
    end
  end

  // Special divides skip iteration: counter 0, precomputed answer parked in r_hi
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_op      <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_mcand   <= '0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_special <= 1'b0;
      r_result  <= '0;
    end else if (w_accept) begin
      r_op      <= op;
      r_lo      <= w_abs_a;
      r_mcand   <= w_abs_b;
      r_neg     <= w_sa ^ w_sb;
      r_neg_rem <= w_sa;
      r_special <= w_div0 || w_ovf;
      if (w_div0) begin
        r_hi  <= op[1] ? a : '1;
        r_cnt <= '0;
      end else if (w_ovf) begin
        r_hi  <= op[1] ? '0 : a;
        r_cnt <= '0;
      end else begin
        r_hi  <= '0;
        r_cnt <= CW'(XLEN);
      end
    end else if (!flush && (r_state == S_BUSY)) begin
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
        if (!r_op[2]) begin
          {r_hi, r_lo} <= {w_mul_sum, r_lo[XLEN-1:1]};
        end else begin
          r_hi <= w_div_trial[XLEN] ? {r_hi[XLEN-2:0], r_lo[XLEN-1]}
                                    : w_div_trial[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], ~w_div_trial[XLEN]};
        end
      end else begin
        r_result <= w_final;
      end
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed and randomized checks of mdu_iterative at XLEN=32.
module tb_mdu_iterative;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] MOST_NEG = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mdu_iterative #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait (bounded) for out_valid, hold off out_ready, then take it
  task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        input int hold, output logic [31:0] res, output int lat);
    op = f; a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (lat < 100) begin
      tick();
      lat++;
      if (out_valid) break;
    end
    repeat (hold) tick();
    res = result;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x,
                                            input logic [31:0] y);
    longint px, py;
    logic [63:0] p;
    logic [31:0] r;
    r = '0;
    case (f)
      3'd0: begin p = {32'b0, x} * {32'b0, y}; r = p[31:0]; end
      3'd1: begin px = longint'($signed(x)); py = longint'($signed(y)); p = px * py; r = p[63:32]; end
      3'd2: begin px = longint'($signed(x)); py = longint'({32'b0, y}); p = px * py; r = p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; r = p[63:32]; end
      3'd4: r = (y == 0) ? 32'hFFFF_FFFF : (x == MOST_NEG && y == 32'hFFFF_FFFF) ? x
              : 32'($signed(x) / $signed(y));
      3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: r = (y == 0) ? x : (x == MOST_NEG && y == 32'hFFFF_FFFF) ? 32'd0
              : 32'($signed(x) % $signed(y));
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    tick(); tick();
    rst_n = 1'b1;
    n_total++;
    if ({in_ready, out_valid, busy, result} !== {1'b1, 1'b0, 1'b0, 32'd0})
      $display("FAIL reset: rdy/vld/busy/res = %b%b%b %h, required 100 00000000",
               in_ready, out_valid, busy, result);
    else n_pass++;
  endtask

  task automatic test_vectors();
    logic [2:0]  f[12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7,
                           3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] x[12] = '{32'd7, MOST_NEG, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                           32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                           32'd5, 32'd5, MOST_NEG, MOST_NEG};
    logic [31:0] y[12] = '{32'hFFFF_FFFD, MOST_NEG, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                           32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                           32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] e[12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                           32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                           32'hFFFF_FFFF, 32'd5, MOST_NEG, 32'd0};
    int          el[12] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
    logic [31:0] res;
    int          lat;
    for (int i = 0; i < 12; i++) begin
      run_op(f[i], x[i], y[i], 0, res, lat);
      n_total++;
      if (res !== e[i]) $display("FAIL vec%0d result: got %h, required %h", i, res, e[i]);
      else n_pass++;
      n_total++;
      if (lat !== el[i]) $display("FAIL vec%0d latency: got %0d, required %0d", i, lat, el[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    op = 3'd5; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    tick();
    op = 3'd0; a = 32'd9; b = 32'd9;
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    for (int i = 0; i < 10; i++) begin
      n_total++;
      if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 32'd14})
        $display("FAIL hold%0d: vld/rdy/res = %b%b %h, required 10 0000000e",
                 i, out_valid, in_ready, result);
      else n_pass++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_total++;
    if ({in_ready, out_valid, busy} !== 3'b100)
      $display("FAIL after_hold: rdy/vld/busy = %b%b%b, required 100", in_ready, out_valid, busy);
    else n_pass++;
  endtask

  task automatic test_abort(input bit use_reset);
    logic [31:0] res;
    int          lat;
    int          seen;
    op = 3'd4; a = 32'd1000; b = 32'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    if (use_reset) rst_n = 1'b0; else flush = 1'b1;
    tick();
    rst_n = 1'b1; flush = 1'b0;
    n_total++;
    if ({in_ready, out_valid, busy} !== 3'b100)
      $display("FAIL abort%0d idle: rdy/vld/busy = %b%b%b, required 100",
               use_reset, in_ready, out_valid, busy);
    else n_pass++;
    seen = 0;
    repeat (40) begin tick(); if (out_valid) seen++; end
    n_total++;
    if (seen !== 0) $display("FAIL abort%0d quiet: out_valid cycles %0d, required 0", use_reset, seen);
    else n_pass++;
    run_op(3'd0, 32'd3, 32'd4, 0, res, lat);
    n_total++;
    if (res !== 32'd12) $display("FAIL abort%0d mul: got %h, required 0000000c", use_reset, res);
    else n_pass++;
  endtask

  task automatic test_flush_idle();
    flush = 1'b1; in_valid = 1'b1; op = 3'd0; a = 32'd2; b = 32'd2;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_total++;
    if ({in_ready, busy} !== 2'b10)
      $display("FAIL flush_idle: rdy/busy = %b%b, required 10", in_ready, busy);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] x, y, res, exp;
    int          lat, el, sel;
    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      x = (sel == 0) ? MOST_NEG : $urandom;
      y = (sel == 1) ? 32'd0 : (sel == 0 || sel == 2) ? 32'hFFFF_FFFF
          : (sel == 3) ? 32'($urandom_range(1, 255)) : $urandom;
      exp = ref_model(f, x, y);
      el = (f[2] && (y == 0 || (!f[0] && x == MOST_NEG && y == 32'hFFFF_FFFF))) ? 1 : 33;
      run_op(f, x, y, $urandom_range(0, 2), res, lat);
      n_total++;
      if (res !== exp || lat !== el)
        $display("FAIL rand%0d op%0d a=%h b=%h: got %h lat %0d, required %h lat %0d",
                 i, f, x, y, res, lat, exp, el);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_abort(1'b0);
    test_abort(1'b1);
    test_flush_idle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
